// File: rtl/ntt_controller.sv
// ============================================================================
// Module   : ntt_controller
// Brief    : Sequencing controller for the Kyber butterfly unit. Runs a full
//            256-point NTT or INTT (seven layers of 128 butterflies), issuing
//            one butterfly per cycle. Generates coefficient-RAM read and
//            write-back addresses, the twiddle-ROM index and the butterfly
//            valid/inverse controls. Write-back is aligned to the butterfly
//            latency with a fixed-depth delay line.
// Options  : NTT_CTRL_HOLD_EN - adds input 'hold', which stalls issue while
//            in the ISSUE state. The delay line keeps draining while stalled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_controller #(
    parameter int RD_LAT = 1,   // coefficient RAM / twiddle ROM read latency
    parameter int BF_LAT = 3,   // butterfly input-to-output latency
    parameter int SETTLE = 3    // cycles bf_inverse is stable before first issue
) (
    input  logic       clk,
    input  logic       r,           // asynchronous, active-low reset
    input  logic       start,
    input  logic       mode_inv,
`ifdef NTT_CTRL_HOLD_EN
    input  logic       hold,
`endif
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic       bf_valid,
    output logic       bf_inverse,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b,
    output logic [2:0] layer
);

    // Total read-to-write-back delay, also the length of the inter-layer drain
    localparam int              c_WL          = RD_LAT + BF_LAT;
    localparam int              c_CW          = 8;
    localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE - 1);
    localparam logic [c_CW-1:0] c_DRAIN_LAST  = c_CW'(c_WL - 1);
    localparam logic [6:0]      c_B_LAST      = 7'd127;
    localparam logic [2:0]      c_L_LAST      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [6:0]      r_b;        // butterfly index within the layer
    logic [2:0]      r_l;        // layer index
    logic [c_CW-1:0] r_cnt;      // SETTLE / DRAIN cycle counter
    logic            r_inv;      // latched mode_inv

    logic            w_hold;
    logic            w_rd_en;

    // Address generation intermediates
    logic [2:0]      w_sh;       // log2(len)
    logic [7:0]      w_len;
    logic [7:0]      w_mask;
    logic [6:0]      w_g;        // group index
    logic [7:0]      w_o;        // offset inside group
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [6:0]      w_tw;

    // Delay lines: rd_en -> bf_valid, and {rd_en, addresses} -> write-back
    logic            r_vld_sr [RD_LAT];
    logic            r_wr_sr  [c_WL];
    logic [7:0]      r_wa_sr  [c_WL];
    logic [7:0]      r_wb_sr  [c_WL];

`ifdef NTT_CTRL_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and issue strobe
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en = !w_hold;
                if (!w_hold && (r_b == c_B_LAST)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    w_next = (r_l == c_L_LAST) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Layer / butterfly / phase counters and the latched direction
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_b   <= '0;
            r_l   <= '0;
            r_cnt <= '0;
            r_inv <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_inv <= mode_inv;
                        r_l   <= '0;
                        r_b   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= (r_cnt == c_SETTLE_LAST) ? '0 : r_cnt + 1'b1;
                end
                S_ISSUE: begin
                    // b wraps 127 -> 0, ready for the next layer
                    if (!w_hold) begin
                        r_b <= r_b + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == c_DRAIN_LAST) begin
                        r_cnt <= '0;
                        if (r_l != c_L_LAST) begin
                            r_l <= r_l + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Butterfly operand and twiddle addresses for the current (l, b)
    always_comb begin
        // Forward layers shrink the span 128..2, inverse layers grow it 2..128
        w_sh   = r_inv ? (r_l + 3'd1) : (3'd7 - r_l);
        w_len  = 8'd1 << w_sh;
        w_mask = w_len - 8'd1;
        w_g    = r_b >> w_sh;
        w_o    = {1'b0, r_b} & w_mask;
        w_a    = (({1'b0, w_g} << w_sh) << 1) | w_o;
        w_b    = w_a + w_len;
        // Forward walks zetas upward from 1; inverse walks downward from 127
        w_tw   = r_inv ? ((7'd127 >> r_l) - w_g) : ((7'd1 << r_l) + w_g);
    end

    // Read-side delay to butterfly valid
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_vld_sr[i] <= 1'b0;
            end
        end else begin
            r_vld_sr[0] <= w_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
        end
    end

    // Write-back delay line; shifts unconditionally so stalls become bubbles
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            for (int i = 0; i < c_WL; i++) begin
                r_wr_sr[i] <= 1'b0;
                r_wa_sr[i] <= '0;
                r_wb_sr[i] <= '0;
            end
        end else begin
            r_wr_sr[0] <= w_rd_en;
            r_wa_sr[0] <= w_rd_en ? w_a : 8'd0;
            r_wb_sr[0] <= w_rd_en ? w_b : 8'd0;
            for (int i = 1; i < c_WL; i++) begin
                r_wr_sr[i] <= r_wr_sr[i-1];
                r_wa_sr[i] <= r_wa_sr[i-1];
                r_wb_sr[i] <= r_wb_sr[i-1];
            end
        end
    end

    // Outputs; read addresses are zero whenever no read is issued
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign rd_en      = w_rd_en;
    assign rd_addr_a  = w_rd_en ? w_a  : 8'd0;
    assign rd_addr_b  = w_rd_en ? w_b  : 8'd0;
    assign tw_addr    = w_rd_en ? w_tw : 7'd0;
    assign bf_valid   = r_vld_sr[RD_LAT-1];
    assign bf_inverse = r_inv;
    assign wr_en      = r_wr_sr[c_WL-1];
    assign wr_addr_a  = r_wa_sr[c_WL-1];
    assign wr_addr_b  = r_wb_sr[c_WL-1];
    assign layer      = r_l;

endmodule

`default_nettype wire

// File: doc/ntt_controller.md
# ntt_controller

Sequencing controller for the Kyber butterfly unit: runs a full 256-point NTT or INTT, one butterfly per issue cycle. It generates coefficient-RAM read/write addresses, the twiddle-ROM address, the butterfly `valid_in` and `inverse` controls, and the write-back enables aligned to the butterfly latency. It sits between the top-level polynomial engine (start/done handshake) and the coefficient RAM, twiddle ROM and butterfly datapath.

## Interface
- `RD_LAT`, 1: read latency of the coefficient RAM and twiddle ROM, in cycles.
- `BF_LAT`, 3: butterfly input-to-output latency, in cycles.
- `SETTLE`, 3: cycles `bf_inverse` is held stable before the first issue (butterfly inverse-flag pipe depth).
- `clk`  in  1  single clock; all state on rising edge.
- `r`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin operation; sampled only in IDLE.
- `mode_inv`  in  1  0 = forward NTT, 1 = INTT; sampled with `start`.
- `busy`  out  1  high from first cycle after accept through DONE.
- `done`  out  1  one-cycle pulse when all results are written.
- `rd_en`  out  1  issue strobe to RAM/ROM.
- `rd_addr_a`, `rd_addr_b`  out  8 each  butterfly operand addresses.
- `tw_addr`  out  7  twiddle-ROM index.
- `bf_valid`  out  1  `rd_en` delayed `RD_LAT`; drives butterfly `valid_in`.
- `bf_inverse`  out  1  latched `mode_inv`; drives butterfly `inverse`.
- `wr_en`  out  1  write-back strobe.
- `wr_addr_a`, `wr_addr_b`  out  8 each  write-back addresses for U_OUT / V_OUT.
- `layer`  out  3  current layer, 0..6.

## Operation
- FSM states: IDLE, SETTLE, ISSUE, DRAIN, DONE.
  - IDLE + `start` → SETTLE: latch `mode_inv` into `bf_inverse`; clear layer `l` and butterfly counter `b`.
  - SETTLE: lasts `SETTLE` cycles, then → ISSUE.
  - ISSUE: lasts 128 cycles, `b` = 0..127, `rd_en` = 1 every cycle; at `b` = 127 → DRAIN.
  - DRAIN: lasts `RD_LAT+BF_LAT` cycles, with no reads. This prevents read-after-write hazards across layers. Then → ISSUE with `l+1`, or → DONE if `l` = 6.
  - DONE: `done` = 1 for one cycle, → IDLE.
- Length per layer: forward `len = 128 >> l`; inverse `len = 2 << l`.
- Address generation: `g = b >> log2(len)`, `o = b & (len-1)`; `rd_addr_a = 2*g*len + o`; `rd_addr_b = rd_addr_a + len`.
- Twiddle index: forward `tw_addr = (1 << l) + g`; inverse `tw_addr = (128 >> l) - 1 - g`. The inverse sequence covers 127 down to 1.
- Write path: a `RD_LAT+BF_LAT`-deep shift register carries `rd_en`, `rd_addr_a` and `rd_addr_b`, giving `wr_en`, `wr_addr_a` and `wr_addr_b`.
- The butterfly applies the per-layer /2 in INTT, so no final scaling pass is performed.
- `start` while busy is ignored.
- `bf_inverse` is held constant from accept until the cycle after DONE.
- Reset: all outputs and state go to 0 and the FSM goes to IDLE immediately, including mid-operation. In-flight writes are dropped.

## Timing
- Edge E0 accepts `start`. Cycle n is the interval after edge En.
- With default parameters:
  - SETTLE occupies cycles 1–3.
  - Layer `l` issues in cycles 4+132·l through 131+132·l, and drains for the following 4 cycles.
  - Per-butterfly timing: `rd_en` at cycle t → `bf_valid` at t+1 → `wr_en` at t+4, carrying the same addresses.
  - Last issue at cycle 923, last `wr_en` at cycle 927, `done` at cycle 928.
  - `busy` is high for cycles 1–928.
- Total latency: `SETTLE + 7·(128 + RD_LAT + BF_LAT) + 1` cycles.

## Configuration
- `NTT_CTRL_HOLD_EN` defined: adds input `hold` (1 bit).
  - In ISSUE, `hold` = 1 freezes `b`, `l` and the FSM, and forces `rd_en` = 0.
  - The delay line keeps shifting, so in-flight butterflies still write back and the bubbles propagate.
  - `hold` is ignored in all other states.
  - Each held cycle in ISSUE delays `done` by one cycle.
- `NTT_CTRL_HOLD_EN` undefined: the port is absent and issue is never stalled.

## Test plan
- Reset: drive `r` = 0 → every output is 0 and `busy` = 0; after release, the FSM is idle until `start`.
- Forward NTT, `start` with `mode_inv` = 0:
  - first issue is (0,128) with tw 1; b=127 of layer 0 is (127,255);
  - layer 1 b=64 is (128,192) with tw 3; last issue is (253,255) with tw 127;
  - `done` at cycle 928.
- INTT, `mode_inv` = 1:
  - `bf_inverse` = 1 from cycle 1; first three issues are (0,2) tw 127, (1,3) tw 127, (4,6) tw 126;
  - layer 6 first issue is (0,128) with tw 1;
  - `done` at cycle 928.
- Alignment: every `wr_en` comes exactly 4 cycles after its `rd_en`, with identical addresses; no `rd_en` in layer l+1 before the last `wr_en` of layer l; exactly 896 `wr_en` pulses.
- Start and reset handling:
  - `start` pulsed at cycle 300 is ignored and `done` stays at 928;
  - `r` asserted during layer 3 → outputs zero asynchronously; a new `start` restarts at layer 0 with address (0,128).
- With `NTT_CTRL_HOLD_EN`: `hold` = 1 for cycles 500–504 → no `rd_en` in those cycles, the `wr_en` count is still 896, and `done` moves to cycle 933.
